controller_seq: RTL and testbench

//  Parametrised successor to the single-bus CPU controller: a multi-cycle fetch/decode/execute

---
 rtl/controller_seq_pkg.sv | 43 ++++
 rtl/ctl_regfile.sv | 63 ++++++
 rtl/controller_seq.sv | 187 ++++++++++++++++++
 tb/tb_controller_seq.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/controller_seq_pkg.sv
// -----------------------------------------------------------------------------
// controller_seq_pkg
//   Shared definitions for the controller_seq instruction sequencer:
//   opcode encodings, opcode field width, FSM state encoding and small
//   opcode classification helpers.
//   No ports (package).
// -----------------------------------------------------------------------------
package controller_seq_pkg;

    // Opcode lives in the top OPC_W bits of the instruction word.
    localparam int OPC_W = 4;

    localparam logic [3:0] OP_NOP  = 4'd0;
    localparam logic [3:0] OP_LDI  = 4'd1;
    localparam logic [3:0] OP_LD   = 4'd2;
    localparam logic [3:0] OP_ST   = 4'd3;
    localparam logic [3:0] OP_JMP  = 4'd4;
    localparam logic [3:0] OP_JZ   = 4'd5;
    localparam logic [3:0] OP_HALT = 4'd6;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_OPND   = 3'd2,
        ST_ACCESS = 3'd3,
        ST_HALT   = 3'd4,
        ST_TRAP   = 3'd5
    } state_t;

    // Opcodes 7..15 have no meaning and trap.
    function automatic logic op_is_defined(input logic [3:0] op);
        return (op <= OP_HALT);
    endfunction

    // Opcodes whose register field must name an existing register.
    function automatic logic op_needs_reg(input logic [3:0] op);
        case (op)
            OP_LDI, OP_LD, OP_ST, OP_JZ: return 1'b1;
            default:                     return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/ctl_regfile.sv
// -----------------------------------------------------------------------------
// ctl_regfile
//   NUM_REGS x DATA_WIDTH operand register file, one write port, async reset
//   to zero. Two read views: one indexed read (data for ST / zero test for JZ)
//   and the whole file flattened for observation.
// Ports
//   clk, rst_n   clock, async active-low reset
//   we           write enable
//   waddr        write register index
//   wdata        write data
//   raddr        read register index
//   rdata        register[raddr] (0 if raddr names no register)
//   regs_flat    register r at [r*DATA_WIDTH +: DATA_WIDTH]
// -----------------------------------------------------------------------------
module ctl_regfile #(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_REGS   = 4,
    parameter int REG_IDX_W  = 2
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           we,
    input  logic [REG_IDX_W-1:0]           waddr,
    input  logic [DATA_WIDTH-1:0]          wdata,
    input  logic [REG_IDX_W-1:0]           raddr,
    output logic [DATA_WIDTH-1:0]          rdata,
    output logic [NUM_REGS*DATA_WIDTH-1:0] regs_flat
);

    logic [DATA_WIDTH-1:0] regs_r [NUM_REGS];

    // Register storage: per-entry compare so an out-of-range index writes nothing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_r[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (we && (waddr == REG_IDX_W'(i))) begin
                    regs_r[i] <= wdata;
                end
            end
        end
    end

    // Indexed read port.
    always_comb begin
        rdata = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            rdata = (raddr == REG_IDX_W'(i)) ? regs_r[i] : rdata;
        end
    end

    // Flattened view of all registers.
    always_comb begin
        regs_flat = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            regs_flat[i*DATA_WIDTH +: DATA_WIDTH] = regs_r[i];
        end
    end

endmodule

// File: rtl/controller_seq.sv
// -----------------------------------------------------------------------------
// controller_seq
//   Multi-cycle fetch/decode/execute sequencer with a req/ack memory port.
//   Owns the instruction pointer; one memory access in flight at a time.
//   Instruction: opcode in the top 4 bits, register index in the low bits.
// Ports
//   clk, rst_n   clock, async active-low reset
//   mem_req      access request, held until mem_ack
//   mem_we       write strobe (ACCESS phase of ST)
//   mem_addr     IP in FETCH/OPND, operand address in ACCESS
//   mem_wdata    register data during the ST write, else 0
//   mem_rdata    read data, taken on mem_ack
//   mem_ack      one-cycle completion pulse, ignored while mem_req=0
//   i_resume     leave HALT/TRAP
//   o_halted     in HALT or TRAP
//   o_illegal    in TRAP
//   o_ip         current instruction pointer
//   o_regs       flattened operand registers
// -----------------------------------------------------------------------------
module controller_seq
    import controller_seq_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 16,
    parameter int NUM_REGS   = 4,
    parameter int RESET_IP   = 0
) (
    input  logic                           clk,
    input  logic                           rst_n,
    output logic                           mem_req,
    output logic                           mem_we,
    output logic [ADDR_WIDTH-1:0]          mem_addr,
    output logic [DATA_WIDTH-1:0]          mem_wdata,
    input  logic [DATA_WIDTH-1:0]          mem_rdata,
    input  logic                           mem_ack,
    input  logic                           i_resume,
    output logic                           o_halted,
    output logic                           o_illegal,
    output logic [ADDR_WIDTH-1:0]          o_ip,
    output logic [NUM_REGS*DATA_WIDTH-1:0] o_regs
);

    localparam int REG_IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [ADDR_WIDTH-1:0] RESET_IP_C = ADDR_WIDTH'(RESET_IP);

    // Only the decoded fields of the instruction word are kept; the rest is ignored.
    state_t                 state_r, state_s;
    logic [ADDR_WIDTH-1:0]  ip_r, ip_s;
    logic [ADDR_WIDTH-1:0]  addr_r, addr_s;
    logic [OPC_W-1:0]       opc_r, opc_s;
    logic [REG_IDX_W-1:0]   ridx_r, ridx_s;

    logic                   rf_we_s;
    logic [DATA_WIDTH-1:0]  rf_rdata_s;
    logic                   reg_ok_s;
    logic                   illegal_s;
    logic [ADDR_WIDTH-1:0]  target_s;
    logic [ADDR_WIDTH-1:0]  ip_inc_s;

    ctl_regfile #(
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_REGS   (NUM_REGS),
        .REG_IDX_W  (REG_IDX_W)
    ) u_regfile (
        .clk       (clk),
        .rst_n     (rst_n),
        .we        (rf_we_s),
        .waddr     (ridx_r),
        .wdata     (mem_rdata),
        .raddr     (ridx_r),
        .rdata     (rf_rdata_s),
        .regs_flat (o_regs)
    );

    // Decode helpers; a register index beyond NUM_REGS is only reachable for non-power-of-2 sizes.
    always_comb begin
        reg_ok_s  = (int'(ridx_r) < NUM_REGS);
        illegal_s = !op_is_defined(opc_r) || (op_needs_reg(opc_r) && !reg_ok_s);
        target_s  = ADDR_WIDTH'(mem_rdata);
        ip_inc_s  = ip_r + ADDR_WIDTH'(1);
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_FETCH;
            ip_r    <= RESET_IP_C;
            addr_r  <= '0;
            opc_r   <= '0;
            ridx_r  <= '0;
        end else begin
            state_r <= state_s;
            ip_r    <= ip_s;
            addr_r  <= addr_s;
            opc_r   <= opc_s;
            ridx_r  <= ridx_s;
        end
    end

    // Next-state logic; jump targets are assigned after the increment so they win.
    always_comb begin
        state_s = state_r;
        ip_s    = ip_r;
        addr_s  = addr_r;
        opc_s   = opc_r;
        ridx_s  = ridx_r;
        rf_we_s = 1'b0;
        case (state_r)
            ST_FETCH: begin
                if (mem_ack) begin
                    opc_s   = mem_rdata[DATA_WIDTH-1 -: OPC_W];
                    ridx_s  = mem_rdata[REG_IDX_W-1:0];
                    ip_s    = ip_inc_s;
                    state_s = ST_DECODE;
                end else begin
                    state_s = ST_FETCH;
                end
            end
            ST_DECODE: begin
                if (illegal_s) begin
                    state_s = ST_TRAP;
                end else begin
                    case (opc_r)
                        OP_NOP:  state_s = ST_FETCH;
                        OP_HALT: state_s = ST_HALT;
                        OP_LDI, OP_LD, OP_ST, OP_JMP, OP_JZ: state_s = ST_OPND;
                        default: state_s = ST_TRAP;
                    endcase
                end
            end
            ST_OPND: begin
                if (mem_ack) begin
                    ip_s = ip_inc_s;
                    case (opc_r)
                        OP_LDI: begin
                            rf_we_s = 1'b1;
                            state_s = ST_FETCH;
                        end
                        OP_LD, OP_ST: begin
                            addr_s  = target_s;
                            state_s = ST_ACCESS;
                        end
                        OP_JMP: begin
                            ip_s    = target_s;
                            state_s = ST_FETCH;
                        end
                        OP_JZ: begin
                            ip_s    = (rf_rdata_s == '0) ? target_s : ip_inc_s;
                            state_s = ST_FETCH;
                        end
                        default: state_s = ST_TRAP;
                    endcase
                end else begin
                    state_s = ST_OPND;
                end
            end
            ST_ACCESS: begin
                if (mem_ack) begin
                    rf_we_s = (opc_r == OP_LD);
                    state_s = ST_FETCH;
                end else begin
                    state_s = ST_ACCESS;
                end
            end
            ST_HALT, ST_TRAP: begin
                if (i_resume) begin
                    state_s = ST_FETCH;
                end else begin
                    state_s = state_r;
                end
            end
            default: state_s = ST_FETCH;
        endcase
    end

    // Moore outputs decoded from the state registers.
    always_comb begin
        mem_req   = (state_r == ST_FETCH) || (state_r == ST_OPND) || (state_r == ST_ACCESS);
        mem_we    = (state_r == ST_ACCESS) && (opc_r == OP_ST);
        mem_addr  = (state_r == ST_ACCESS) ? addr_r : ip_r;
        mem_wdata = mem_we ? rf_rdata_s : '0;
        o_halted  = (state_r == ST_HALT) || (state_r == ST_TRAP);
        o_illegal = (state_r == ST_TRAP);
        o_ip      = ip_r;
    end

endmodule

// File: tb/tb_controller_seq.sv
module tb_controller_seq;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        mem_req, mem_we, mem_ack, i_resume, o_halted, o_illegal;
    logic [15:0] mem_addr, mem_wdata, mem_rdata, o_ip;
    logic [63:0] o_regs;

    logic        mem_req2, mem_we2, mem_ack2, i_resume2, o_halted2, o_illegal2;
    logic [15:0] mem_addr2, mem_wdata2, mem_rdata2, o_ip2;
    logic [47:0] o_regs2;

    int checks   = 0;
    int failures = 0;

    // Main memory model with programmable / random ack delay.
    logic [15:0] mem [0:255];
    logic        model_ack;
    logic        ack_inj;
    int          cnt, cur_delay, fixed_delay;
    bit          rand_mode;
    assign mem_ack = model_ack | ack_inj;

    controller_seq #(.DATA_WIDTH(16), .ADDR_WIDTH(16), .NUM_REGS(4), .RESET_IP(0)) dut (
        .clk(clk), .rst_n(rst_n), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack), .i_resume(i_resume),
        .o_halted(o_halted), .o_illegal(o_illegal), .o_ip(o_ip), .o_regs(o_regs));

    controller_seq #(.DATA_WIDTH(16), .ADDR_WIDTH(16), .NUM_REGS(3), .RESET_IP(16'hFFFF)) dut2 (
        .clk(clk), .rst_n(rst_n), .mem_req(mem_req2), .mem_we(mem_we2), .mem_addr(mem_addr2),
        .mem_wdata(mem_wdata2), .mem_rdata(mem_rdata2), .mem_ack(mem_ack2), .i_resume(i_resume2),
        .o_halted(o_halted2), .o_illegal(o_illegal2), .o_ip(o_ip2), .o_regs(o_regs2));

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            model_ack <= 1'b0;
            cnt       <= 0;
            cur_delay <= fixed_delay;
            mem_rdata <= 16'h0000;
        end else if (model_ack) begin
            model_ack <= 1'b0;
            cnt       <= 0;
            cur_delay <= rand_mode ? int'($urandom_range(0, 3)) : fixed_delay;
        end else if (mem_req) begin
            if (cnt >= cur_delay) begin
                model_ack <= 1'b1;
                mem_rdata <= mem[mem_addr[7:0]];
                if (mem_we) mem[mem_addr[7:0]] <= mem_wdata;
            end else begin
                cnt <= cnt + 1;
            end
        end
    end

    // Fixed ROM for the second instance (RESET_IP=0xFFFF, NUM_REGS=3), zero-wait.
    function automatic logic [15:0] rom2(input logic [15:0] a);
        case (a)
            16'hFFFF: return 16'h1000;   // LDI r0
            16'h0000: return 16'h1234;   // operand after wrap
            16'h0001: return 16'h6000;   // HALT
            16'h0002: return 16'h1003;   // LDI r3 -> illegal with 3 regs
            16'h0003: return 16'hF000;   // illegal opcode
            default:  return 16'h0000;
        endcase
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_ack2   <= 1'b0;
            mem_rdata2 <= 16'h0000;
        end else if (mem_ack2) begin
            mem_ack2 <= 1'b0;
        end else if (mem_req2) begin
            mem_ack2   <= 1'b1;
            mem_rdata2 <= rom2(mem_addr2);
        end
    end

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] <= 16'h0000;
    endtask

    task automatic do_reset(input int delay, input bit rnd);
        rst_n = 1'b0; i_resume = 1'b0; i_resume2 = 1'b0; ack_inj = 1'b0;
        fixed_delay = delay; rand_mode = rnd;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic wait_halt(input int budget, output int cyc);
        cyc = -1;
        for (int i = 1; i <= budget; i++) begin
            @(posedge clk); #1;
            if (o_halted === 1'b1) begin cyc = i; break; end
        end
    endtask

    task automatic wait_halt2(input int budget, output int cyc);
        cyc = -1;
        for (int i = 1; i <= budget; i++) begin
            @(posedge clk); #1;
            if (o_halted2 === 1'b1) begin cyc = i; break; end
        end
    endtask

    task automatic test_reset();
        clear_mem();
        mem[0] <= 16'h6000;
        fixed_delay = 0; rand_mode = 1'b0;
        rst_n = 1'b0; i_resume = 1'b0; i_resume2 = 1'b0; ack_inj = 1'b0;
        @(posedge clk); #1;
        checks++; if (mem_req !== 1'b1)       begin failures++; $display("FAIL rst_req got=%b exp=1", mem_req); end
        checks++; if (mem_addr !== 16'h0000)  begin failures++; $display("FAIL rst_addr got=%h exp=0000", mem_addr); end
        checks++; if (mem_we !== 1'b0)        begin failures++; $display("FAIL rst_we got=%b exp=0", mem_we); end
        checks++; if (mem_wdata !== 16'h0000) begin failures++; $display("FAIL rst_wdata got=%h exp=0000", mem_wdata); end
        checks++; if (o_halted !== 1'b0 || o_illegal !== 1'b0) begin failures++; $display("FAIL rst_flags got=%b%b exp=00", o_halted, o_illegal); end
        checks++; if (o_regs !== 64'h0)       begin failures++; $display("FAIL rst_regs got=%h exp=0", o_regs); end
        checks++; if (mem_addr2 !== 16'hFFFF) begin failures++; $display("FAIL rst_addr2 got=%h exp=ffff", mem_addr2); end
    endtask

    task automatic test_ld_st();
        int cyc;
        clear_mem();
        mem[0] <= 16'h1001; mem[1] <= 16'h00AA;   // LDI r1,0x00AA
        mem[2] <= 16'h3001; mem[3] <= 16'h0040;   // ST  r1,@0x40
        mem[4] <= 16'h2002; mem[5] <= 16'h0040;   // LD  r2,@0x40
        mem[6] <= 16'h6000;                       // HALT
        do_reset(0, 1'b0);
        wait_halt(200, cyc);
        checks++; if (cyc != 22)               begin failures++; $display("FAIL t1_cycles got=%0d exp=22", cyc); end
        checks++; if (o_ip !== 16'h0007)       begin failures++; $display("FAIL t1_ip got=%h exp=0007", o_ip); end
        checks++; if (o_regs[31:16] !== 16'h00AA) begin failures++; $display("FAIL t1_r1 got=%h exp=00aa", o_regs[31:16]); end
        checks++; if (o_regs[47:32] !== 16'h00AA) begin failures++; $display("FAIL t1_r2 got=%h exp=00aa", o_regs[47:32]); end
        checks++; if (mem[8'h40] !== 16'h00AA) begin failures++; $display("FAIL t1_mem40 got=%h exp=00aa", mem[8'h40]); end
        checks++; if (o_illegal !== 1'b0 || mem_req !== 1'b0) begin failures++; $display("FAIL t1_halt_out got=ill%b req%b exp=ill0 req0", o_illegal, mem_req); end
    endtask

    task automatic test_jz();
        int cyc;
        clear_mem();
        mem[8'h00] <= 16'h5000; mem[8'h01] <= 16'h0010;   // JZ r0,0x10 (taken)
        mem[8'h10] <= 16'h1000; mem[8'h11] <= 16'h0001;   // LDI r0,1
        mem[8'h12] <= 16'h5000; mem[8'h13] <= 16'h0000;   // JZ r0,0 (not taken)
        mem[8'h14] <= 16'h6000;                           // HALT
        do_reset(0, 1'b1);
        wait_halt(300, cyc);
        checks++; if (cyc < 0)                 begin failures++; $display("FAIL t2_timeout got=none exp=halt"); end
        checks++; if (o_ip !== 16'h0015)       begin failures++; $display("FAIL t2_ip got=%h exp=0015", o_ip); end
        checks++; if (o_regs[15:0] !== 16'h0001) begin failures++; $display("FAIL t2_r0 got=%h exp=0001", o_regs[15:0]); end
    endtask

    task automatic test_illegal();
        int cyc;
        clear_mem();
        mem[0] <= 16'hF000; mem[1] <= 16'hF000;
        do_reset(0, 1'b0);
        wait_halt(50, cyc);
        checks++; if (cyc != 3)                begin failures++; $display("FAIL t3_cycles got=%0d exp=3", cyc); end
        checks++; if (o_illegal !== 1'b1)      begin failures++; $display("FAIL t3_illegal got=%b exp=1", o_illegal); end
        checks++; if (o_ip !== 16'h0001)       begin failures++; $display("FAIL t3_ip got=%h exp=0001", o_ip); end
        checks++; if (mem_req !== 1'b0)        begin failures++; $display("FAIL t3_req got=%b exp=0", mem_req); end
        i_resume = 1'b1;
        @(posedge clk); #1 i_resume = 1'b0;
        checks++; if (mem_req !== 1'b1 || mem_addr !== 16'h0001 || o_halted !== 1'b0) begin failures++; $display("FAIL t3_refetch got=req%b addr%h h%b exp=req1 addr0001 h0", mem_req, mem_addr, o_halted); end
        wait_halt(50, cyc);
        checks++; if (o_illegal !== 1'b1 || o_ip !== 16'h0002) begin failures++; $display("FAIL t3_retrap got=ill%b ip%h exp=ill1 ip0002", o_illegal, o_ip); end
    endtask

    task automatic test_wrap();
        int cyc;
        clear_mem();
        mem[0] <= 16'h6000;
        do_reset(0, 1'b0);
        wait_halt2(50, cyc);
        checks++; if (cyc != 8)                 begin failures++; $display("FAIL t4_cycles got=%0d exp=8", cyc); end
        checks++; if (o_regs2[15:0] !== 16'h1234) begin failures++; $display("FAIL t4_r0 got=%h exp=1234", o_regs2[15:0]); end
        checks++; if (o_ip2 !== 16'h0002)       begin failures++; $display("FAIL t4_ip got=%h exp=0002", o_ip2); end
        checks++; if (o_illegal2 !== 1'b0)      begin failures++; $display("FAIL t4_illegal got=%b exp=0", o_illegal2); end
    endtask

    task automatic test_bad_reg();
        int cyc;
        i_resume2 = 1'b1;
        @(posedge clk); #1 i_resume2 = 1'b0;
        wait_halt2(50, cyc);
        checks++; if (o_illegal2 !== 1'b1 || o_ip2 !== 16'h0003) begin failures++; $display("FAIL t3b_badreg got=ill%b ip%h exp=ill1 ip0003", o_illegal2, o_ip2); end
        checks++; if (mem_req2 !== 1'b0 || o_regs2 !== {32'h0, 16'h1234}) begin failures++; $display("FAIL t3b_state got=req%b regs%h exp=req0 regs1234", mem_req2, o_regs2); end
        i_resume2 = 1'b1;
        @(posedge clk); #1 i_resume2 = 1'b0;
        wait_halt2(50, cyc);
        checks++; if (o_illegal2 !== 1'b1 || o_ip2 !== 16'h0004) begin failures++; $display("FAIL t3b_badop got=ill%b ip%h exp=ill1 ip0004", o_illegal2, o_ip2); end
    endtask

    task automatic test_reset_mid_access();
        bit seen;
        clear_mem();
        mem[0] <= 16'h1001; mem[1] <= 16'h0055;
        mem[2] <= 16'h3001; mem[3] <= 16'h0040;
        mem[4] <= 16'h6000;
        do_reset(3, 1'b0);
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            if (mem_we === 1'b1) begin seen = 1'b1; break; end
        end
        checks++; if (!seen) begin failures++; $display("FAIL t5_access got=none exp=write"); end
        checks++; if (mem_wdata !== 16'h0055 || mem_addr !== 16'h0040) begin failures++; $display("FAIL t5_wr got=%h@%h exp=0055@0040", mem_wdata, mem_addr); end
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        checks++; if (mem_req !== 1'b1 || mem_addr !== 16'h0000 || mem_we !== 1'b0 || mem_wdata !== 16'h0000) begin failures++; $display("FAIL t5_rst_mem got=req%b addr%h we%b wd%h exp=req1 addr0000 we0 wd0000", mem_req, mem_addr, mem_we, mem_wdata); end
        checks++; if (o_halted !== 1'b0 || o_illegal !== 1'b0 || o_ip !== 16'h0000 || o_regs !== 64'h0) begin failures++; $display("FAIL t5_rst_state got=h%b i%b ip%h regs%h exp=0 0 0000 0", o_halted, o_illegal, o_ip, o_regs); end
        repeat (6) @(posedge clk);
        #1;
        checks++; if (mem[8'h40] !== 16'h0000) begin failures++; $display("FAIL t5_nowrite got=%h exp=0000", mem[8'h40]); end
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++; if (mem_req !== 1'b1 || mem_addr !== 16'h0000) begin failures++; $display("FAIL t5_refetch got=req%b addr%h exp=req1 addr0000", mem_req, mem_addr); end
    endtask

    task automatic test_spurious();
        int cyc;
        clear_mem();
        mem[0] <= 16'h6000; mem[1] <= 16'h0000; mem[2] <= 16'h6000;
        do_reset(3, 1'b0);
        wait_halt(100, cyc);
        checks++; if (cyc < 0 || o_ip !== 16'h0001) begin failures++; $display("FAIL t6_halt got=ip%h exp=ip0001", o_ip); end
        ack_inj = 1'b1;
        @(posedge clk); #1 ack_inj = 1'b0;
        @(posedge clk); #1;
        checks++; if (o_halted !== 1'b1 || o_ip !== 16'h0001 || mem_req !== 1'b0) begin failures++; $display("FAIL t6_ack_halt got=h%b ip%h req%b exp=h1 ip0001 req0", o_halted, o_ip, mem_req); end
        i_resume = 1'b1;
        @(posedge clk); #1 i_resume = 1'b1;
        @(posedge clk); #1 i_resume = 1'b0;
        checks++; if (o_halted !== 1'b0 || mem_req !== 1'b1 || mem_addr !== 16'h0001 || o_ip !== 16'h0001) begin failures++; $display("FAIL t6_resume_fetch got=h%b req%b addr%h ip%h exp=h0 req1 addr0001 ip0001", o_halted, mem_req, mem_addr, o_ip); end
        wait_halt(100, cyc);
        checks++; if (cyc < 0 || o_ip !== 16'h0003 || o_illegal !== 1'b0) begin failures++; $display("FAIL t6_end got=ip%h ill%b exp=ip0003 ill0", o_ip, o_illegal); end
    endtask

    initial begin
        rst_n = 1'b0; i_resume = 1'b0; i_resume2 = 1'b0; ack_inj = 1'b0;
        fixed_delay = 0; rand_mode = 1'b0;
        test_reset();
        test_ld_st();
        test_jz();
        test_illegal();
        test_wrap();
        test_bad_reg();
        test_reset_mid_access();
        test_spurious();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
